// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (configurable data width, parity and stop bits)
// feeding a first-word-fall-through receive FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned OVS        = 16,
  parameter int unsigned BAUD_W     = 32
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [BAUD_W-1:0]             baud_ctl,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(OVS);
  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [BAUD_W-1:0] r_baud_cnt;
  logic              w_tick;
  logic              r_rx_meta, r_rx_sync, r_rx_prev;
  logic              w_fall;

  state_t            r_state;
  logic [TW-1:0]     r_tick_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_en, r_par_odd, r_stop2, r_par_bad;
  logic              r_wr_en;
  logic              r_frame_err, r_parity_err;
  logic              w_mid;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [LW-1:0]     w_level_nxt;
  logic              r_rd_valid, r_overrun;
  logic              w_full, w_pop, w_push_ok;

  // Free-running tick divider; baud_ctl is only picked up on reload.
  assign w_tick = (r_baud_cnt == '0);

  always_ff @(posedge CLK) begin
    if (RESET)       r_baud_cnt <= '0;
    else if (w_tick) r_baud_cnt <= baud_ctl;
    else             r_baud_cnt <= r_baud_cnt - BAUD_W'(1);
  end

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;
  assign w_mid  = (r_tick_cnt == TW'(OVS - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_odd    <= 1'b0;
      r_stop2      <= 1'b0;
      r_par_bad    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      // Clear first so a same-cycle set below takes precedence.
      if (err_clr) begin
        r_frame_err  <= 1'b0;
        r_parity_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state    <= S_START;
            r_tick_cnt <= '0;
            r_par_en   <= parity_en;
            r_par_odd  <= parity_odd;
            r_stop2    <= stop2;
            r_par_bad  <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_tick_cnt == TW'(OVS/2 - 1)) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= r_rx_sync ? S_IDLE : S_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (w_mid) begin
              r_tick_cnt <= '0;
              r_shift    <= {r_rx_sync, r_shift[DATA_W-1:1]};
              if (r_bit_cnt == BW'(DATA_W - 1)) begin
                r_bit_cnt <= '0;
                r_state   <= r_par_en ? S_PARITY : S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            if (w_mid) begin
              r_tick_cnt <= '0;
              r_state    <= S_STOP;
              if (r_rx_sync != ((^r_shift) ^ r_par_odd)) begin
                r_par_bad    <= 1'b1;
                r_parity_err <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_mid) begin
              r_tick_cnt <= '0;
              if (!r_rx_sync) begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
              end else if (r_stop2 && (r_bit_cnt == '0)) begin
                r_bit_cnt <= BW'(1);
              end else begin
                r_wr_en <= ~r_par_bad;
                r_state <= S_IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_pop     = rd_en & r_rd_valid;
  assign w_push_ok = r_wr_en & (~w_full | w_pop);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push_ok && !w_pop)      w_level_nxt = r_level + LW'(1);
    else if (!w_push_ok && w_pop) w_level_nxt = r_level - LW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RESET && w_push_ok) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rd_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level    <= w_level_nxt;
      r_rd_valid <= (w_level_nxt != '0);
      if (r_wr_en && w_full && !w_pop) r_overrun <= 1'b1;
      else if (err_clr)                r_overrun <= 1'b0;
    end
  end

  assign rd_data    = r_rd_valid ? r_mem[r_rd_ptr] : '0;
  assign rd_valid   = r_rd_valid;
  assign fifo_level = r_level;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule
